execute_cc_stage: RTL and testbench

// Execute-stage back end of the Y-86 pipeline: consumes operands/result of the 64-bit ALU (add/sub/and/xor),

---
 rtl/y86_pkg.sv | 20 ++
 rtl/cond_eval.sv | 21 ++
 rtl/execute_cc_stage.sv | 60 ++++++
 tb/tb_execute_cc_stage.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// y86_pkg: shared Y-86 icode, ifun, register and condition-code constants
package y86_pkg;
  localparam logic [3:0] I_NOP = 4'h1;
  localparam logic [3:0] I_CMOV = 4'h2;
  localparam logic [3:0] I_OPQ = 4'h6;
  localparam logic [3:0] I_JXX = 4'h7;
  localparam logic [3:0] ALU_ADD = 4'h0;
  localparam logic [3:0] ALU_SUB = 4'h1;
  localparam logic [3:0] ALU_AND = 4'h2;
  localparam logic [3:0] ALU_XOR = 4'h3;
  localparam logic [3:0] C_ALWAYS = 4'h0;
  localparam logic [3:0] C_LE = 4'h1;
  localparam logic [3:0] C_L = 4'h2;
  localparam logic [3:0] C_E = 4'h3;
  localparam logic [3:0] C_NE = 4'h4;
  localparam logic [3:0] C_GE = 4'h5;
  localparam logic [3:0] C_G = 4'h6;
  localparam logic [3:0] REG_NONE = 4'hF;
  localparam logic [2:0] CC_RST = 3'b100;
endpackage

// File: rtl/cond_eval.sv
// cond_eval: jXX/cmovXX condition from {ZF,SF,OF} and ifun
module cond_eval
  import y86_pkg::*;
(
  input  logic [2:0] cc,
  input  logic [3:0] ifun,
  output logic       cnd
);
  logic zf, sf, of, lt;
  assign {zf, sf, of} = cc;
  assign lt = sf ^ of;
  always_comb begin
    cnd = ifun == C_ALWAYS ? 1'b1 :
          ifun == C_LE     ? lt | zf :
          ifun == C_L      ? lt :
          ifun == C_E      ? zf :
          ifun == C_NE     ? ~zf :
          ifun == C_GE     ? ~lt :
          ifun == C_G      ? ~lt & ~zf : 1'b0;
  end
endmodule

// File: rtl/execute_cc_stage.sv
// execute_cc_stage: Y-86 execute back end -- flags, CC register, cmov gating and E->M register
module execute_cc_stage #(
  parameter int W = 64,
  parameter logic [2:0] CC_RST = y86_pkg::CC_RST
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         e_valid,
  input  logic [3:0]   e_icode,
  input  logic [3:0]   e_ifun,
  input  logic [3:0]   e_dstE,
  input  logic [W-1:0] alu_a,
  input  logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_result,
  input  logic         set_cc_en,
  input  logic         m_stall,
  input  logic         m_bubble,
  output logic [2:0]   cc,
  output logic         e_cnd,
  output logic [3:0]   e_dstE_eff,
  output logic         M_valid,
  output logic [3:0]   M_icode,
  output logic         M_cnd,
  output logic [W-1:0] M_valE,
  output logic [3:0]   M_dstE
);
  import y86_pkg::*;
  logic zf, sf, of, a_s, b_s, r_s;
  assign {a_s, b_s, r_s} = {alu_a[W-1], alu_b[W-1], alu_result[W-1]};
  assign zf = alu_result == '0;
  assign sf = r_s;
  always_comb begin
    of = e_ifun == ALU_ADD ? (a_s == b_s) & (r_s != a_s) :
         e_ifun == ALU_SUB ? (a_s != b_s) & (r_s != b_s) : 1'b0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n)
      cc <= CC_RST;
    else if (e_valid && e_icode == I_OPQ && set_cc_en)
      cc <= {zf, sf, of};
  end
  cond_eval u_cond (.cc(cc), .ifun(e_ifun), .cnd(e_cnd));
  assign e_dstE_eff = (e_icode == I_CMOV && !e_cnd) ? REG_NONE : e_dstE;
  // bubble shares the reset image so downstream sees an ordinary nop
  always_ff @(posedge clk) begin
    if (!rst_n || m_bubble) begin
      M_valid <= 1'b0;
      M_icode <= I_NOP;
      M_cnd   <= 1'b0;
      M_valE  <= '0;
      M_dstE  <= REG_NONE;
    end else if (!m_stall) begin
      M_valid <= e_valid;
      M_icode <= e_valid ? e_icode : I_NOP;
      M_cnd   <= e_cnd;
      M_valE  <= alu_result;
      M_dstE  <= e_dstE_eff;
    end
  end
endmodule

// File: tb/tb_execute_cc_stage.sv
// tb_execute_cc_stage: directed checks of flags, conditions, cmov gating and M register control
module tb_execute_cc_stage;
  logic clk = 1'b0, rst_n, e_valid, set_cc_en, m_stall, m_bubble;
  logic [3:0] e_icode, e_ifun, e_dstE;
  logic [63:0] alu_a, alu_b, alu_result;
  logic [2:0] cc;
  logic e_cnd, M_valid, M_cnd;
  logic [3:0] e_dstE_eff, M_icode, M_dstE;
  logic [63:0] M_valE;
  int checks = 0, errors = 0;

  execute_cc_stage dut (
    .clk(clk), .rst_n(rst_n), .e_valid(e_valid), .e_icode(e_icode), .e_ifun(e_ifun),
    .e_dstE(e_dstE), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .set_cc_en(set_cc_en), .m_stall(m_stall), .m_bubble(m_bubble), .cc(cc), .e_cnd(e_cnd),
    .e_dstE_eff(e_dstE_eff), .M_valid(M_valid), .M_icode(M_icode), .M_cnd(M_cnd),
    .M_valE(M_valE), .M_dstE(M_dstE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] r);
    e_valid = 1'b1;
    e_icode = icode;
    e_ifun = ifun;
    alu_a = a;
    alu_b = b;
    alu_result = r;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; e_valid = 1'b1; set_cc_en = 1'b1; m_stall = 1'b0; m_bubble = 1'b0;
    e_icode = 4'h0; e_ifun = 4'h3; e_dstE = 4'h5;
    alu_a = 64'h1; alu_b = 64'h1; alu_result = 64'h2;
    tick();
    chk("rst_cc", cc, 3'b100);
    chk("rst_mvalid", M_valid, 0);
    chk("rst_micode", M_icode, 4'h1);
    chk("rst_mdste", M_dstE, 4'hF);
    chk("rst_mvale", M_valE, 0);
    chk("rst_ecnd_e", e_cnd, 1);
    rst_n = 1'b1;
    // XOR flags; e_cnd must still reflect old cc (ZF=1) this cycle
    drive(4'h6, 4'h3, 64'h1, 64'h5, 64'h4);
    chk("xor_same_cycle_cnd", e_cnd, 1);
    tick();
    chk("xor1_cc", cc, 3'b000);
    chk("xor1_mvalid", M_valid, 1);
    chk("xor1_micode", M_icode, 4'h6);
    chk("xor1_mvale", M_valE, 64'h4);
    chk("xor1_mdste", M_dstE, 4'h5);
    drive(4'h6, 4'h3, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFB, 64'h7FFF_FFFF_FFFF_FFFB);
    tick();
    chk("xor2_cc", cc, 3'b000);
    drive(4'h6, 4'h3, 64'h1234, 64'h1234, 64'h0);
    tick();
    chk("xor3_cc", cc, 3'b100);
    // ADD overflow
    drive(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    chk("add_of_cc", cc, 3'b011);
    drive(4'h7, 4'h2, 0, 0, 0);
    chk("cnd_l", e_cnd, 0);
    drive(4'h7, 4'h1, 0, 0, 0);
    chk("cnd_le", e_cnd, 0);
    drive(4'h7, 4'h5, 0, 0, 0);
    chk("cnd_ge", e_cnd, 1);
    drive(4'h7, 4'h6, 0, 0, 0);
    chk("cnd_g", e_cnd, 1);
    drive(4'h7, 4'h4, 0, 0, 0);
    chk("cnd_ne", e_cnd, 1);
    drive(4'h7, 4'h9, 0, 0, 0);
    chk("cnd_undef", e_cnd, 0);
    drive(4'h7, 4'h0, 0, 0, 0);
    tick();
    chk("jxx_mcnd", M_cnd, 1);
    chk("jxx_cc_hold", cc, 3'b011);
    // SUB overflow, then CC write suppressed
    drive(4'h6, 4'h1, 64'h1, 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF);
    tick();
    chk("sub_of_cc", cc, 3'b001);
    set_cc_en = 1'b0;
    drive(4'h6, 4'h3, 64'h5, 64'h5, 64'h0);
    tick();
    chk("setcc_off_cc", cc, 3'b001);
    set_cc_en = 1'b1;
    tick();
    chk("cc_to_zf", cc, 3'b100);
    // cmov gating
    e_dstE = 4'h3;
    drive(4'h2, 4'h4, 0, 64'h77, 64'h77);
    chk("cmov_ne_cnd", e_cnd, 0);
    chk("cmov_ne_dst", e_dstE_eff, 4'hF);
    tick();
    chk("cmov_ne_mdst", M_dstE, 4'hF);
    chk("cmov_ne_mcnd", M_cnd, 0);
    drive(4'h2, 4'h3, 0, 64'h77, 64'h77);
    chk("cmov_e_dst", e_dstE_eff, 4'h3);
    tick();
    chk("cmov_e_mdst", M_dstE, 4'h3);
    chk("cmov_e_mcnd", M_cnd, 1);
    // pipeline control
    set_cc_en = 1'b0;
    drive(4'h6, 4'h0, 64'h0, 64'hDEAD, 64'hDEAD);
    tick();
    chk("load_mvale", M_valE, 64'hDEAD);
    m_stall = 1'b1;
    drive(4'h6, 4'h0, 64'h0, 64'hBEEF, 64'hBEEF);
    tick();
    chk("stall1_mvale", M_valE, 64'hDEAD);
    tick();
    chk("stall2_mvale", M_valE, 64'hDEAD);
    chk("stall2_micode", M_icode, 4'h6);
    m_bubble = 1'b1;
    tick();
    chk("stbub_mvalid", M_valid, 0);
    chk("stbub_micode", M_icode, 4'h1);
    chk("stbub_mvale", M_valE, 0);
    chk("stbub_mdste", M_dstE, 4'hF);
    m_bubble = 1'b0;
    set_cc_en = 1'b1;
    drive(4'h6, 4'h0, 64'h1, 64'h1, 64'h2);
    tick();
    chk("stall_cc_upd", cc, 3'b000);
    chk("stall_cc_mvale", M_valE, 0);
    rst_n = 1'b0;
    drive(4'h6, 4'h3, 64'h0, 64'h9, 64'h9);
    tick();
    chk("rst_stall_cc", cc, 3'b100);
    chk("rst_stall_mvalid", M_valid, 0);
    chk("rst_stall_micode", M_icode, 4'h1);
    rst_n = 1'b1;
    m_stall = 1'b0;
    e_valid = 1'b0;
    e_icode = 4'h6;
    alu_result = 64'h55;
    tick();
    chk("inv_mvalid", M_valid, 0);
    chk("inv_micode", M_icode, 4'h1);
    chk("inv_mvale", M_valE, 64'h55);
    chk("inv_cc", cc, 3'b100);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
